// File: rtl/iir_decim_out.sv
// Boxcar-average decimator with a first-word-fall-through output FIFO.
// Sums R = 2**LOG2R consecutive valid samples, pushes floor(sum / R) into the
// FIFO, and flags (sticky) any decimated sample lost to a full FIFO.
module iir_decim_out #(
  parameter int BITWIDTH = 32,
  parameter int LOG2R    = 2,
  parameter int DEPTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [BITWIDTH-1:0]       in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BITWIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      overflow,
  input  logic                      clr_ovf
);

  localparam int R   = 1 << LOG2R;
  localparam int AW  = BITWIDTH + LOG2R;          // wide enough that R samples never wrap
  localparam int PHW = (LOG2R > 0) ? LOG2R : 1;   // keep a legal width in pass-through mode
  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;

  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  sum;
  logic [PHW-1:0]        phase;
  logic                  last_phase;
  logic [BITWIDTH-1:0]   result;

  logic [BITWIDTH-1:0]   mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic                  full;
  logic                  push_req;
  logic                  push;
  logic                  pop;

  // Running sum including the current sample; the cast sign-extends in_data.
  assign sum        = acc + AW'($signed(in_data));
  assign last_phase = (phase == PHW'(R - 1));
  // Arithmetic shift of a signed value floors toward -inf; the average always fits BITWIDTH.
  assign result     = BITWIDTH'(sum >>> LOG2R);

  assign full     = (level == LW'(DEPTH));
  assign pop      = out_valid && out_ready;
  assign push_req = in_valid && last_phase;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign push     = push_req && (!full || pop);

  assign out_valid  = (level != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;

  // Accumulate valid samples and restart the block after the R-th one.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    if (rst) begin
      acc   <= '0;
      phase <= '0;
    end else if (in_valid) begin
      if (last_phase) begin
        acc   <= '0;
        phase <= '0;
      end else begin
        acc   <= sum;
        phase <= phase + PHW'(1);
      end
    end
  end

  // FIFO storage: written on accepted pushes only.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers and level define
    // which entries are meaningful, and leaving it unreset lets it map to RAM.
    if (push && !rst) begin
      mem[wr_ptr] <= result;
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      // A drop in the same cycle as a clear wins so no loss goes unreported.
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
